handshake_constant_buffered: RTL and testbench
==============================================

Name: handshake_constant_buffered

Overview:
Parametrised, elastic successor to the combinational dataflow constant.
- Each token accepted on ctrl becomes one output token carrying the compile-time constant VALUE.
- Accepted tokens are stored in an internal token counter up to DEPTH. This decouples ctrl_ready from outs_ready and breaks the combinational valid/ready path through the constant.
- Used wherever a constant feeds a long or timing-critical handshake chain in generated dataflow circuits.

Parameters:
- DATA_WIDTH, 32: width of outs.
- VALUE, 0: constant driven on outs, truncated or zero-extended to DATA_WIDTH.
- DEPTH, 2: maximum number of stored tokens; legal range 1..255.
- CNT_WIDTH, $clog2(DEPTH+1): counter width; derived, must not be overridden.

Ports:
- clk, in, 1: clock; all state updates on rising edge.
- rst, in, 1: reset; synchronous, active-low (rst==0 at a rising clk edge resets).
- ctrl_valid, in, 1: incoming token valid.
- ctrl_ready, out, 1: block can accept a ctrl token.
- outs, out, DATA_WIDTH: constant data, always VALUE.
- outs_valid, out, 1: output token available.
- outs_ready, in, 1: downstream accepts output token.

Behaviour:
- State:
  - cnt: 0..DEPTH, number of stored tokens.
  - full_q: registered (cnt==DEPTH).
  - empty_q: registered (cnt==0).
- Reset (rst==0 at edge): cnt=0, full_q=0, empty_q=1. Consequently outs_valid=0 and ctrl_ready=1 from the first cycle after reset.
- outs = VALUE at all times, including during reset.
- outs_valid = ~empty_q.
- ctrl_ready = ~full_q.
- Neither output depends combinationally on any input (default build).
- Transfers:
  - in_fire = ctrl_valid & ctrl_ready.
  - out_fire = outs_valid & outs_ready.
- Counter update:
  - in_fire only: cnt+1.
  - out_fire only: cnt-1.
  - Both or neither: cnt unchanged.
- Flags are recomputed from the next cnt value, so they never lag cnt.
- Latency: a token accepted in cycle t is visible on outs_valid in cycle t+1.
- Throughput:
  - DEPTH>=2: 1 token/cycle sustained.
  - DEPTH==1: alternate cycles (full blocks input while output drains).
- Full (cnt==DEPTH): ctrl_ready=0; ctrl_valid is ignored. A simultaneous out_fire frees a slot for the next cycle only.
- Empty (cnt==0): outs_valid=0; outs_ready is ignored.
- No overflow or underflow is possible by construction. The bench asserts cnt<=DEPTH.
- Reset mid-operation: all stored tokens are discarded; no output token is produced for them.
- AXI-style rule: outs_valid, once high, stays high until out_fire (guaranteed because cnt only decrements on out_fire).

Optional Feature:
- Macro: HANDSHAKE_CONSTANT_BYPASS_EN.
- Defined:
  - When cnt==0 and ctrl_valid==1, outs_valid=1 combinationally (zero latency).
  - If outs_ready==1 in that cycle, the token passes straight through and cnt stays 0.
  - ctrl_ready remains registered (~full_q).
  - Cost: introduces a comb path ctrl_valid->outs_valid.
- Undefined: behaviour exactly as above; minimum latency 1 cycle.

Decomposition:
- Shared package handshake_pkg holds:
  - function clog2_min1 (returns >=1) for CNT_WIDTH.
  - localparam-style typedef cnt_t sized from DEPTH.
  - enum-free constants CNT_INC/CNT_DEC/CNT_HOLD for update selection.
- Natural sub-module: handshake_token_counter (params DEPTH).
  - Inputs: inc, dec.
  - Outputs: registered full, empty, count.
  - Reusable by future elastic constant/source blocks.
- Top module adds the VALUE driver and the optional bypass.

Test Plan:
- Reset: hold rst=0 for 3 cycles with ctrl_valid=1 -> outs_valid=0, ctrl_ready=1 throughout; after release, outs=VALUE.
- Single token, DEPTH=2, VALUE=8'hFF, DATA_WIDTH=8: ctrl_valid=1 for 1 cycle, outs_ready=1 -> outs_valid=1 exactly one cycle later, outs=8'hFF, cnt back to 0.
- Fill/backpressure: outs_ready=0, ctrl_valid=1 for 5 cycles, DEPTH=2 -> exactly 2 tokens accepted, ctrl_ready=0 from the 3rd cycle; then outs_ready=1 -> exactly 2 outs transfers.
- Streaming: DEPTH=2, both sides always valid/ready for 100 cycles -> 99 output transfers, cnt constant at 1, no bubble.
- Simultaneous at full: cnt=2, ctrl_valid=1, outs_ready=1 -> no input accepted that cycle, one output; next cycle ctrl_ready=1.
- Bypass (macro defined), cnt=0: ctrl_valid=1, outs_ready=1 -> outs_valid=1 same cycle, transfer completes, cnt stays 0. Mid-stream reset with cnt=2 -> next cycle outs_valid=0, no stale tokens emitted.

Source files
------------

// File: rtl/handshake_pkg.sv
// Shared handshake helpers: counter sizing and the up/down/hold selector
// codes used by the elastic token counters.
package handshake_pkg;

    localparam int DEPTH_MAX = 255;

    // Never returns 0, so a counter is at least one bit wide.
    function automatic int clog2_min1(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

    // Widest counter any legal DEPTH can need; handy for debug buses.
    typedef logic [clog2_min1(DEPTH_MAX + 1)-1:0] cnt_t;

    localparam logic [1:0] CNT_HOLD = 2'd0;
    localparam logic [1:0] CNT_INC  = 2'd1;
    localparam logic [1:0] CNT_DEC  = 2'd2;

    // Simultaneous inc and dec cancel out and leave the count untouched.
    function automatic logic [1:0] cnt_sel(input logic inc, input logic dec);
        logic [1:0] sel;
        sel = CNT_HOLD;
        if (inc && !dec) begin
            sel = CNT_INC;
        end else if (dec && !inc) begin
            sel = CNT_DEC;
        end
        return sel;
    endfunction

endpackage

// File: rtl/handshake_token_counter.sv
// Token counter 0..DEPTH with full/empty flags registered from the next
// count, so the flags never lag the count.
module handshake_token_counter
    import handshake_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = clog2_min1(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_next;
    logic          full_q;
    logic          empty_q;
    logic [1:0]    sel;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        sel      = cnt_sel(inc, dec);
        cnt_next = cnt_q;
        case (sel)
            CNT_INC: cnt_next = cnt_q + 1'b1;
            CNT_DEC: cnt_next = cnt_q - 1'b1;
            default: cnt_next = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_next;
            full_q  <= (cnt_next == DEPTH_C);
            empty_q <= (cnt_next == '0);
        end
    end

    assign full  = full_q;
    assign empty = empty_q;
    assign count = cnt_q;

endmodule

// File: rtl/handshake_constant_buffered.sv
// Elastic dataflow constant: each ctrl token becomes one outs token carrying VALUE.
// Define HANDSHAKE_CONSTANT_BYPASS_EN for a zero-latency path when no tokens are stored.
module handshake_constant_buffered
    import handshake_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter logic [63:0] VALUE      = 64'd0,
    parameter int          DEPTH      = 2,
    parameter int          CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_valid,
    output logic                  ctrl_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    logic                 full_q;
    logic                 empty_q;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 in_fire;
    logic                 out_fire;

    assign outs       = DATA_WIDTH'(VALUE);
    assign ctrl_ready = ~full_q;

`ifdef HANDSHAKE_CONSTANT_BYPASS_EN
    // Pass-through when empty: inc and dec fire together, so cnt stays 0.
    // Gated by rst so nothing is offered while the block is held in reset.
    assign outs_valid = ~empty_q | (ctrl_valid & rst);
`else
    assign outs_valid = ~empty_q;
`endif

    assign in_fire  = ctrl_valid & ctrl_ready;
    assign out_fire = outs_valid & outs_ready;

    handshake_token_counter #(
        .DEPTH (DEPTH)
    ) u_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (in_fire),
        .dec   (out_fire),
        .full  (full_q),
        .empty (empty_q),
        .count (cnt)
    );

    cnt_in_range: assert property (@(posedge clk) disable iff (!rst) cnt <= CNT_WIDTH'(DEPTH));

endmodule

// File: tb/tb_handshake_constant_buffered.sv
// Scoreboard bench for handshake_constant_buffered: a queue of pending tokens is
// the reference model; a monitor compares handshakes and data every cycle.
module tb_handshake_constant_buffered;

    localparam int              DATA_WIDTH = 8;
    localparam logic [7:0]      VALUE      = 8'hFF;
    localparam int              DEPTH      = 2;
`ifdef HANDSHAKE_CONSTANT_BYPASS_EN
    localparam bit              BYPASS     = 1'b1;
`else
    localparam bit              BYPASS     = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  ctrl_valid = 1'b0;
    logic                  ctrl_ready;
    logic [DATA_WIDTH-1:0] outs;
    logic                  outs_valid;
    logic                  outs_ready = 1'b0;

    int checks   = 0;
    int failures = 0;
    int n_in     = 0;
    int n_out    = 0;
    logic [DATA_WIDTH-1:0] exp_q[$];

    handshake_constant_buffered #(
        .DATA_WIDTH (DATA_WIDTH),
        .VALUE      (64'(VALUE)),
        .DEPTH      (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ctrl_valid (ctrl_valid),
        .ctrl_ready (ctrl_ready),
        .outs       (outs),
        .outs_valid (outs_valid),
        .outs_ready (outs_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: runs mid-cycle, compares against the queue, then applies the
    // transfers the coming rising edge will commit.
    initial begin
        logic exp_ready;
        logic exp_valid;
        @(posedge clk);
        forever begin
            @(negedge clk);
            #2;
            exp_ready = exp_q.size() < DEPTH;
            exp_valid = (exp_q.size() > 0) || (BYPASS && ctrl_valid && rst);
            check("ctrl_ready", ctrl_ready, exp_ready);
            check("outs_valid", outs_valid, exp_valid);
            check("outs_const", outs, VALUE);
            check("cnt", dut.cnt, exp_q.size());
            check("cnt_le_depth", dut.cnt <= DEPTH, 1'b1);
            if (!rst) begin
                exp_q.delete();
            end else begin
                if (ctrl_valid && exp_ready) begin
                    exp_q.push_back(VALUE);
                    n_in++;
                end
                if (outs_valid && outs_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL spurious_output: got transfer expected none at %0t", $time);
                    end else begin
                        check("outs_data", outs, exp_q.pop_front());
                    end
                    n_out++;
                end
            end
        end
    end

    initial begin
        int in0;
        int out0;

        // Reset held for three edges with ctrl_valid asserted.
        rst = 1'b0; ctrl_valid = 1'b1; outs_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1; ctrl_valid = 1'b0;

        // Single token.
        in0 = n_in; out0 = n_out;
        ctrl_valid = 1'b1; outs_ready = 1'b1;
        @(negedge clk);
        ctrl_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("single_in", n_in - in0, 1);
        check("single_out", n_out - out0, 1);

        // Fill under backpressure, then drain.
        in0 = n_in;
        ctrl_valid = 1'b1; outs_ready = 1'b0;
        repeat (5) @(negedge clk);
        check("fill_accepted", n_in - in0, DEPTH);
        out0 = n_out;
        ctrl_valid = 1'b0; outs_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("drain_transfers", n_out - out0, DEPTH);

        // Streaming with both sides always ready.
        in0 = n_in; out0 = n_out;
        ctrl_valid = 1'b1; outs_ready = 1'b1;
        repeat (100) @(negedge clk);
        check("stream_in", n_in - in0, 100);
        check("stream_out", n_out - out0, BYPASS ? 100 : 99);
        ctrl_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Simultaneous request and drain while full.
        ctrl_valid = 1'b1; outs_ready = 1'b0;
        repeat (DEPTH) @(negedge clk);
        in0 = n_in; out0 = n_out;
        outs_ready = 1'b1;
        @(negedge clk);
        check("full_sim_in", n_in - in0, 0);
        check("full_sim_out", n_out - out0, 1);
        #1;
        check("ready_after_full", ctrl_ready, 1'b1);
        ctrl_valid = 1'b0;
        repeat (4) @(negedge clk);

        // Mid-stream reset with the buffer full: stored tokens vanish.
        ctrl_valid = 1'b1; outs_ready = 1'b0;
        repeat (DEPTH) @(negedge clk);
        out0 = n_out;
        rst = 1'b0; ctrl_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1; outs_ready = 1'b1;
        #1;
        check("valid_after_reset", outs_valid, 1'b0);
        repeat (3) @(negedge clk);
        check("reset_discard", n_out - out0, 0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            ctrl_valid = ($urandom_range(0, 3) != 0);
            outs_ready = ($urandom_range(0, 2) != 0);
            rst        = ($urandom_range(0, 63) != 0);
            @(negedge clk);
        end

        rst = 1'b1; ctrl_valid = 1'b0; outs_ready = 1'b1;
        repeat (DEPTH + 3) @(negedge clk);
        #1;
        check("end_empty", outs_valid, 1'b0);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
